// File: rtl/ps2_receiver.sv
// PS/2 receiver: turns raw device clock/data into checked scan codes queued in a small FIFO.
// Latency: a byte is visible on data/ready 4 clk cycles after the ps2_clk falling edge of its stop bit.
// Backpressure: consumer pops with nextdata_n=0; a valid byte arriving at a full FIFO is dropped (sticky overflow).
// Ports: clk/reset (sync, active-high), ps2_clk/ps2_data (async raw bus), nextdata_n (active-low pop),
//        data (FIFO head), ready (FIFO not empty), overflow (sticky drop flag), frame_err (1-cycle bad-frame pulse).
module ps2_receiver #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);

    // ------------------------------------------------------------------
    // Synchronisers (reset to 1 = idle bus) and falling-edge detect
    // ------------------------------------------------------------------
    logic [2:0] clk_sync;
    logic [2:0] dat_sync;
    logic       clk_prev;
    logic       fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= 3'b111;
            dat_sync <= 3'b111;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            dat_sync <= {dat_sync[1:0], ps2_data};
            clk_prev <= clk_sync[2];
        end
    end

    assign fall = clk_prev & ~clk_sync[2];

    // ------------------------------------------------------------------
    // Frame assembly
    // ------------------------------------------------------------------
    logic [10:0]   shreg;
    logic [10:0]   shreg_next;
    logic [3:0]    bit_cnt;
    logic [IW-1:0] idle_cnt;
    logic          frame_done;
    logic          frame_ok;
    logic          timeout;

    // Shift in from the top so that after 11 bits the start bit sits at [0].
    assign shreg_next = {dat_sync[2], shreg[10:1]};
    assign frame_done = fall && (bit_cnt == 4'd10);
    // start=0, stop=1, odd parity over data+parity bits
    assign frame_ok   = ~shreg_next[0] & shreg_next[10] & (^shreg_next[9:1]);
    assign timeout    = (idle_cnt == IDLE_MAX) && (bit_cnt != 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            idle_cnt <= '0;
        end else if (fall) begin
            shreg    <= shreg_next;
            idle_cnt <= '0;
            bit_cnt  <= frame_done ? 4'd0 : bit_cnt + 4'd1;
        end else if (timeout) begin
            // Stalled device: abandon the partial frame silently.
            bit_cnt  <= '0;
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Scan-code FIFO (pointers carry one wrap bit)
    // ------------------------------------------------------------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push;
    logic        drop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop   = ~nextdata_n & ~empty;
    // A simultaneous pop frees a slot, so a full FIFO still accepts the byte.
    assign push  = frame_done & frame_ok & (~full | pop);
    assign drop  = frame_done & frame_ok & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= shreg_next[8:1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            frame_err <= frame_done & ~frame_ok;
        end
    end

    assign ready = ~empty;
    assign data  = mem[rptr[AW-1:0]];

endmodule

// File: tb/tb_ps2_receiver.sv
// Bench for ps2_receiver: directed PS/2 frames, a queue model of the scan-code FIFO,
// and a per-cycle compare of ready/data/overflow/frame_err against that model.
module tb_ps2_receiver;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    ps2_receiver #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(4096)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    byte unsigned mq[$];
    bit           m_ovf = 1'b0;
    int           m_err = 0;
    bit           chk_en = 1'b0;

    // Observed frame_err activity
    int obs_err_pulses = 0;
    int obs_err_hi = 0;
    bit err_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (frame_err === 1'b1) obs_err_hi++;
        if (frame_err === 1'b1 && !err_prev) obs_err_pulses++;
        err_prev = (frame_err === 1'b1);
        if (chk_en) begin
            chk("ready", ready, mq.size() != 0);
            if (mq.size() != 0) chk("data", data, mq[0]);
            chk("overflow", overflow, m_ovf);
            chk("frame_err_quiet", frame_err, 0);
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit par_ok,
                                             input logic start, input logic stop);
        logic p;
        p = ~(^b);
        if (!par_ok) p = ~p;
        return {stop, p, b, start};
    endfunction

    // One PS/2 bit; with pop_at_edge the consumer pops in the exact cycle the
    // falling edge reaches the frame logic (3 sync flops + edge detect).
    task automatic send_bit(input logic b, input bit pop_at_edge);
        ps2_data = b;
        wait_clk(4);
        ps2_clk = 1'b0;
        if (pop_at_edge) begin
            wait_clk(3);
            nextdata_n = 1'b0;
            wait_clk(1);
            nextdata_n = 1'b1;
            wait_clk(4);
        end else begin
            wait_clk(8);
        end
        ps2_clk = 1'b1;
        wait_clk(4);
    endtask

    task automatic model_apply(input logic [10:0] f, input bit pop_req);
        bit valid;
        valid = (f[0] == 1'b0) && (f[10] == 1'b1) && ((^f[9:1]) == 1'b1);
        if (pop_req && mq.size() > 0) mq.delete(0);
        if (!valid) m_err++;
        else if (mq.size() < DEPTH) mq.push_back(f[8:1]);
        else m_ovf = 1'b1;
    endtask

    task automatic do_frame(input logic [10:0] f, input bit pop_last);
        chk_en = 1'b0;
        for (int i = 0; i < 10; i++) send_bit(f[i], 1'b0);
        send_bit(f[10], pop_last);
        wait_clk(2);
        model_apply(f, pop_last);
        chk("frame_err_pulses", obs_err_pulses, m_err);
        chk("frame_err_width", obs_err_hi, m_err);
        chk_en = 1'b1;
    endtask

    task automatic do_pop();
        nextdata_n = 1'b0;
        wait_clk(1);
        nextdata_n = 1'b1;
        if (mq.size() > 0) mq.delete(0);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        reset = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        wait_clk(1);
        chk_en = 1'b1;
    endtask

    initial begin
        logic [10:0] f;
        int err_before;

        // Reset state
        wait_clk(3);
        chk("rst_ready", ready, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_err", frame_err, 0);
        reset = 1'b0;
        wait_clk(1);
        chk_en = 1'b1;

        // Single good frame 0x1C, then pop
        do_frame(mk_frame(8'h1C, 1'b1, 1'b0, 1'b1), 1'b0);
        chk("t1_ready", ready, 1);
        chk("t1_data", data, 8'h1C);
        do_pop();
        chk("t1_ready_popped", ready, 0);
        do_pop();
        chk("t1_pop_empty", ready, 0);

        // Bad parity, bad stop, bad start
        do_frame(mk_frame(8'h1C, 1'b0, 1'b0, 1'b1), 1'b0);
        chk("t2_err_cnt", obs_err_pulses, 1);
        chk("t2_ready", ready, 0);
        chk("t2_overflow", overflow, 0);
        do_frame(mk_frame(8'hA5, 1'b1, 1'b0, 1'b0), 1'b0);
        do_frame(mk_frame(8'h5A, 1'b1, 1'b1, 1'b1), 1'b0);
        chk("t2_err_total", obs_err_pulses, 3);
        chk("t2_ready_after_bad", ready, 0);

        // Overflow: 9 frames, no pops
        for (int i = 1; i <= 9; i++) do_frame(mk_frame(8'(i), 1'b1, 1'b0, 1'b1), 1'b0);
        chk("t3_overflow", overflow, 1);
        for (int i = 1; i <= 8; i++) begin
            chk("t3_drain_data", data, i);
            do_pop();
        end
        chk("t3_ready_empty", ready, 0);
        chk("t3_overflow_sticky", overflow, 1);

        // Full FIFO with a pop in the push cycle
        do_reset();
        chk("t4_overflow_cleared", overflow, 0);
        for (int i = 1; i <= 8; i++) do_frame(mk_frame(8'(i), 1'b1, 1'b0, 1'b1), 1'b0);
        do_frame(mk_frame(8'h09, 1'b1, 1'b0, 1'b1), 1'b1);
        chk("t4_overflow", overflow, 0);
        chk("t4_head", data, 8'h02);
        for (int i = 2; i <= 9; i++) begin
            chk("t4_drain_data", data, i);
            do_pop();
        end
        chk("t4_ready_empty", ready, 0);

        // Partial frame abandoned by idle timeout
        do_reset();
        err_before = obs_err_pulses;
        chk_en = 1'b0;
        f = mk_frame(8'h77, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) send_bit(f[i], 1'b0);
        chk_en = 1'b1;
        wait_clk(4200);
        chk("t5_no_err_timeout", obs_err_pulses, err_before);
        do_frame(mk_frame(8'hF0, 1'b1, 1'b0, 1'b1), 1'b0);
        chk("t5_data", data, 8'hF0);
        chk("t5_no_err", obs_err_pulses, err_before);
        do_pop();

        // Reset in the middle of a frame
        chk_en = 1'b0;
        f = mk_frame(8'hAB, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) send_bit(f[i], 1'b0);
        do_reset();
        do_frame(mk_frame(8'h32, 1'b1, 1'b0, 1'b1), 1'b0);
        chk("t6_data", data, 8'h32);
        chk("t6_overflow", overflow, 0);
        do_pop();
        chk("t6_only_one", ready, 0);

        wait_clk(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, giving the number of scan-code FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, giving the clk cycles without a PS/2 falling edge after which a partial frame is abandoned.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ps2_clk, input, 1 bit: raw PS/2 device clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data, input, 1 bit: raw PS/2 device data, asynchronous to clk.
REQ-007 SHALL have port nextdata_n, input, 1 bit: active-low pop request from the downstream consumer.
REQ-008 SHALL have port data, output, 8 bits: the scan code at the FIFO head.
REQ-009 SHALL have port ready, output, 1 bit: high when the FIFO holds at least one entry.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag set when a valid frame is dropped because the FIFO is full.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a received frame fails its checks.

Function
REQ-012 SHALL synchronise ps2_clk and ps2_data through 3-flop chains; the falling edge is detected as synced value 0 with previous synced value 1.
REQ-013 SHALL sample synced ps2_data once per detected falling edge into an 11-bit shift register, LSB first, counting bits with a 4-bit counter 0..10.
REQ-014 SHALL evaluate the frame on the edge that samples the 11th bit, then clear the bit counter to 0 in the same cycle.
REQ-015 SHALL treat a frame as valid only when start=0, stop=1, and XOR of the 8 data bits and the parity bit =1 (odd parity).
REQ-016 SHALL, for a valid frame with FIFO not full, write the 8 data bits at the write pointer; the entry becomes visible on data/ready the cycle after the 11th-bit edge.
REQ-017 SHALL, for a valid frame with FIFO full, discard the byte, set overflow=1 and hold it until reset, leaving FIFO contents unchanged.
REQ-018 SHALL, for an invalid frame, pulse frame_err=1 for exactly one cycle and write nothing to the FIFO.
REQ-019 SHALL drive data combinationally from FIFO[rptr]; data is don't-care when ready=0.
REQ-020 SHALL pop one entry (advance rptr) on each clk edge where nextdata_n=0 and ready=1; nextdata_n=0 with ready=0 has no effect.
REQ-021 SHALL support push and pop in the same cycle, leaving the occupancy unchanged; a push into a full FIFO that pops in the same cycle SHALL succeed without setting overflow.
REQ-022 SHALL use read/write pointers one bit wider than log2(FIFO_DEPTH), wrapping modulo 2*FIFO_DEPTH: empty when the pointers are equal; full when the MSBs differ and the rest are equal.
REQ-023 SHALL hold an idle counter that clears on every falling edge and saturates at TIMEOUT_CYCLES; on reaching it with bit counter ≠0, the counter returns to 0 and the partial frame is dropped without frame_err.

Reset
REQ-024 SHALL, while reset=1 at a clk edge, clear pointers, bit counter, shift register and idle counter, and set overflow=0, frame_err=0, ready=0, and the synchroniser flops to 1 (idle bus).
REQ-025 SHALL, on a reset asserted mid-frame, discard the partial frame; the first falling edge after reset deassertion is bit 0 of a new frame.
REQ-026 SHALL not require reset for FIFO storage contents; data is unspecified until the first push.

Verification
REQ-027 SHALL pass: frame 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1 incl. start/parity=0/stop) -> ready=1, data=8'h1C; one cycle of nextdata_n=0 -> ready=0.
REQ-028 SHALL pass: frame 0x1C with parity bit=1 -> frame_err pulses 1 cycle, ready stays 0, overflow=0.
REQ-029 SHALL pass: 9 valid frames 0x01..0x09 with no pops -> overflow=1 after the 9th; 8 pops return 0x01..0x08, then ready=0.
REQ-030 SHALL pass: FIFO full, with nextdata_n=0 held in the cycle the 9th frame completes -> overflow=0, occupancy stays 8, head advances to 0x02.
REQ-031 SHALL pass: 5 bits sent, then 4096 idle cycles, then full frame 0xF0 -> data=8'hF0, no frame_err.
REQ-032 SHALL pass: reset pulsed after 6 bits of a frame, then full frame 0x32 -> only 0x32 is queued, overflow=0.
